llvga_stream: RTL
=================

Name: llvga_stream

Overview:
- Parametrised next-generation low-level VGA/DVI timing generator.
- Generalised in colour depth and counter width. Adds mode shadowing with a frame-boundary update, programmable sync polarity, and a data-enable output.
- Pixel input is a valid/ready stream with start-of-frame framing and a lock/resync state machine. Underflow is detected and counted.
- Sits between the frame-buffer reader (stream source) and the VGA/HDMI output pins or encoder.

Parameters:
- BPC, 8, bits per colour channel; pixel is 3*BPC wide, ordered {R,G,B}.
- HW, 12, horizontal mode/counter width.
- VW, 12, vertical mode/counter width.

Ports:
- i_pixclk  in  1  pixel clock; the block's only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_test  in  1  1 = internal colour bars; the stream is ignored.
- i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw  in  HW each  active width, sync start, sync end, total line length.
- i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw  in  VW each  vertical equivalents.
- i_hsync_pol, i_vsync_pol  in  1 each  1 = sync pulse is active-high.
- i_valid  in  1  stream pixel valid.
- o_ready  out  1  stream ready.
- i_pixel  in  3*BPC  stream pixel data.
- i_sof  in  1  marks the first pixel of a frame.
- o_de  out  1  data enable (active video).
- o_hsync, o_vsync  out  1 each  polarity-applied sync outputs.
- o_red, o_grn, o_blu  out  BPC each  colour outputs.
- o_newline  out  1  one-cycle pulse, last cycle of each line.
- o_newframe  out  1  one-cycle pulse, last cycle of each frame.
- o_locked  out  1  state machine is in LOCKED.
- o_underflow  out  1  one-cycle pulse, aligned with a blacked-out pixel.
- o_sync_err  out  1  one-cycle pulse on a framing error.
- o_underflow_count  out  16  saturating underflow counter.

Behaviour:
- Mode shadowing:
  - All 8 geometry inputs and both polarity inputs are copied into shadow registers during reset.
  - They are copied again on the cycle where hpos==raw-1 and vpos==vraw-1 (frame end).
  - At all other times the live inputs are ignored; all comparisons use the shadow registers.
  - Legal mode: 16<width<porch<synch<raw, and likewise for the vertical set. Behaviour with an illegal mode is undefined.
- Counters:
  - hpos counts 0..raw-1 and then wraps to 0.
  - vpos advances only when hpos wraps, counting 0..vraw-1 and then wrapping.
  - Counter comparisons are unsigned, HW/VW bits wide.
- Outputs are registered one cycle after the counter state that produces them:
  - o_de = (hpos<width)&&(vpos<height).
  - o_hsync = (porch<=hpos<synch) XNOR hpol.
  - o_vsync = (vporch<=vpos<vsynch) XNOR vpol.
  - o_newline = (hpos==raw-1).
  - o_newframe = (hpos==raw-1)&&(vpos==vraw-1).
- Pixel latency: a beat accepted in cycle N appears on o_red/o_grn/o_blu in cycle N+1, aligned with o_de. Colour outputs are 0 whenever o_de is 0.
- State machine (states HUNT, WAIT, LOCKED; reset state HUNT):
  - HUNT:
    - o_ready = !i_sof (combinational; depends only on i_sof), so non-sof beats are discarded.
    - When i_valid&&i_sof → WAIT; the sof beat is not consumed.
  - WAIT:
    - o_ready=0.
    - On the cycle where the counters are at (0,0) → LOCKED. That cycle itself behaves as LOCKED for readiness.
  - LOCKED:
    - o_ready = active(hpos,vpos) && !i_test.
    - Accepted beat with i_sof at a position other than (0,0), or with !i_sof at (0,0): the beat is consumed and displayed, o_sync_err pulses, and the next state is HUNT.
  - In HUNT and WAIT, active pixels are output black and o_underflow is not asserted.
- Underflow:
  - Condition: LOCKED, active position, !i_test, !i_valid.
  - Result: black pixel, o_underflow pulses aligned with that pixel, and the counter increments, saturating at 16'hFFFF.
  - The counter is cleared only by reset. An underflow does not cause loss of lock.
- Test mode (i_test=1):
  - o_ready=0; the state machine holds its state.
  - Eight vertical bars of width width>>3, tracked by a bar-pixel counter and a 3-bit bar index. The index resets at hpos==0 and saturates at 7 for any remainder pixels.
  - Bar k colour: R = full scale if bit 2 of (7-k) is set, G per bit 1, B per bit 0.
- Reset (synchronous, any cycle, including mid-frame):
  - hpos=vpos=0; state=HUNT; counter=0.
  - o_de, o_newline, o_newframe, o_underflow, o_sync_err, o_locked and colours = 0.
  - o_hsync = !i_hsync_pol and o_vsync = !i_vsync_pol (inactive levels).
  - o_ready=0 while i_reset is high.

Test Plan:
- 640x480 mode (800/525 totals, hsync 656..751, vsync 490..491), pol=0, stream always valid, sof correct:
  - o_locked rises by the start of frame 2.
  - o_hsync is low for exactly 96 cycles per line; o_de is high for 640 cycles per line.
  - One o_newframe every 420000 cycles; pixel data appears 1 cycle after acceptance.
- While locked, drop i_valid for 3 active pixels → 3 o_underflow pulses, 3 black pixels, count=3, o_locked stays 1.
- Inject i_sof on pixel (5,0) → o_sync_err pulse, o_locked=0, discards until the next sof, relock at the next (0,0).
- Change i_hm_width from 640 to 320 mid-frame → the current frame keeps 640-wide o_de; the next frame is 320 wide.
- i_test=1, width=640 → bars 80 pixels wide, first bar white, last bar black, o_ready=0 throughout.
- Assert i_reset mid-line with pol=1 → next cycle o_hsync=0, o_vsync=0, o_de=0, count=0, state HUNT.

Source files
------------

// File: rtl/llvga_stream.sv
// Parametrised VGA/DVI timing generator fed by a valid/ready pixel stream.
// Mode registers are shadowed and only reloaded at reset or on the last cycle of a frame.
module llvga_stream #(
  parameter int BPC = 8,
  parameter int HW  = 12,
  parameter int VW  = 12
) (
  input  logic             i_pixclk,
  input  logic             i_reset,
  input  logic             i_test,
  input  logic [HW-1:0]    i_hm_width,
  input  logic [HW-1:0]    i_hm_porch,
  input  logic [HW-1:0]    i_hm_synch,
  input  logic [HW-1:0]    i_hm_raw,
  input  logic [VW-1:0]    i_vm_height,
  input  logic [VW-1:0]    i_vm_porch,
  input  logic [VW-1:0]    i_vm_synch,
  input  logic [VW-1:0]    i_vm_raw,
  input  logic             i_hsync_pol,
  input  logic             i_vsync_pol,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3*BPC-1:0] i_pixel,
  input  logic             i_sof,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [BPC-1:0]   o_red,
  output logic [BPC-1:0]   o_grn,
  output logic [BPC-1:0]   o_blu,
  output logic             o_newline,
  output logic             o_newframe,
  output logic             o_locked,
  output logic             o_underflow,
  output logic             o_sync_err,
  output logic [15:0]      o_underflow_count
);

  typedef enum logic [1:0] {HUNT = 2'd0, WAIT = 2'd1, LOCKED = 2'd2} state_t;

  logic [HW-1:0]    hm_width_r, hm_porch_r, hm_synch_r, hm_raw_r;
  logic [VW-1:0]    vm_height_r, vm_porch_r, vm_synch_r, vm_raw_r;
  logic             hpol_r, vpol_r;
  logic [HW-1:0]    hpos_r, bar_cnt_r;
  logic [VW-1:0]    vpos_r;
  logic [2:0]       bar_idx_r;
  state_t           state_r, state_nx_s;
  logic             de_r, hsync_r, vsync_r, newline_r, newframe_r;
  logic             locked_r, underflow_r, sync_err_r;
  logic [3*BPC-1:0] rgb_r, pix_nx_s, bar_rgb_s;
  logic [15:0]      uf_count_r;
  logic             hlast_s, vlast_s, frame_end_s, active_s, origin_s;
  logic             ready_s, eff_lock_s, sync_err_s, underflow_s, accept_s;
  logic [HW-1:0]    bar_w_s;
  logic [2:0]       bar_c_s;

  // Position decode against the shadowed mode.
  always_comb begin
    hlast_s     = (hpos_r == hm_raw_r - HW'(1));
    vlast_s     = (vpos_r == vm_raw_r - VW'(1));
    frame_end_s = hlast_s && vlast_s;
    active_s    = (hpos_r < hm_width_r) && (vpos_r < vm_height_r);
    origin_s    = (hpos_r == HW'(0)) && (vpos_r == VW'(0));
    bar_w_s     = hm_width_r >> 3;
    bar_c_s     = ~bar_idx_r;
    bar_rgb_s   = {{BPC{bar_c_s[2]}}, {BPC{bar_c_s[1]}}, {BPC{bar_c_s[0]}}};
  end

  // Lock state machine: next state, stream readiness and framing errors.
  always_comb begin
    state_nx_s = state_r;
    ready_s    = 1'b0;
    eff_lock_s = 1'b0;
    sync_err_s = 1'b0;
    case (state_r)
      HUNT: begin
        ready_s = !i_sof;
        if (i_valid && i_sof) state_nx_s = WAIT;
        else                  state_nx_s = HUNT;
      end
      WAIT: begin
        // The origin cycle is already treated as locked so the sof beat is taken there.
        if (origin_s) begin
          eff_lock_s = 1'b1;
          ready_s    = active_s;
          state_nx_s = LOCKED;
        end else begin
          state_nx_s = WAIT;
        end
      end
      LOCKED: begin
        eff_lock_s = 1'b1;
        ready_s    = active_s;
        state_nx_s = LOCKED;
      end
      default: state_nx_s = HUNT;
    endcase
    if (i_test) begin
      ready_s    = 1'b0;
      state_nx_s = state_r;
    end else if (eff_lock_s && ready_s && i_valid && (i_sof != origin_s)) begin
      sync_err_s = 1'b1;
      state_nx_s = HUNT;
    end else begin
      sync_err_s = 1'b0;
    end
  end

  // Pixel selection: colour bars, accepted stream beat, or black.
  always_comb begin
    accept_s    = i_valid && ready_s;
    underflow_s = eff_lock_s && active_s && !i_test && !i_valid;
    pix_nx_s    = {(3*BPC){1'b0}};
    if (i_test) begin
      if (active_s) pix_nx_s = bar_rgb_s;
      else          pix_nx_s = {(3*BPC){1'b0}};
    end else if (eff_lock_s && accept_s) begin
      pix_nx_s = i_pixel;
    end else begin
      pix_nx_s = {(3*BPC){1'b0}};
    end
  end

  assign o_ready = ready_s && !i_reset;

  // Mode shadow registers.
  always_ff @(posedge i_pixclk) begin
    if (i_reset || frame_end_s) begin
      hm_width_r  <= i_hm_width;
      hm_porch_r  <= i_hm_porch;
      hm_synch_r  <= i_hm_synch;
      hm_raw_r    <= i_hm_raw;
      vm_height_r <= i_vm_height;
      vm_porch_r  <= i_vm_porch;
      vm_synch_r  <= i_vm_synch;
      vm_raw_r    <= i_vm_raw;
      hpol_r      <= i_hsync_pol;
      vpol_r      <= i_vsync_pol;
    end
  end

  // Position counters, colour-bar tracking and lock state.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      hpos_r    <= HW'(0);
      vpos_r    <= VW'(0);
      bar_cnt_r <= HW'(0);
      bar_idx_r <= 3'd0;
      state_r   <= HUNT;
    end else begin
      hpos_r  <= hlast_s ? HW'(0) : hpos_r + HW'(1);
      if (hlast_s) vpos_r <= vlast_s ? VW'(0) : vpos_r + VW'(1);
      state_r <= state_nx_s;
      if (hlast_s) begin
        bar_cnt_r <= HW'(0);
        bar_idx_r <= 3'd0;
      end else if (bar_cnt_r == bar_w_s - HW'(1)) begin
        bar_cnt_r <= HW'(0);
        if (bar_idx_r != 3'd7) bar_idx_r <= bar_idx_r + 3'd1;
      end else begin
        bar_cnt_r <= bar_cnt_r + HW'(1);
      end
    end
  end

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge i_pixclk) begin
    if (i_reset) begin
      de_r        <= 1'b0;
      hsync_r     <= !i_hsync_pol;
      vsync_r     <= !i_vsync_pol;
      newline_r   <= 1'b0;
      newframe_r  <= 1'b0;
      locked_r    <= 1'b0;
      underflow_r <= 1'b0;
      sync_err_r  <= 1'b0;
      rgb_r       <= {(3*BPC){1'b0}};
      uf_count_r  <= 16'd0;
    end else begin
      de_r        <= active_s;
      hsync_r     <= ((hpos_r >= hm_porch_r) && (hpos_r < hm_synch_r)) ~^ hpol_r;
      vsync_r     <= ((vpos_r >= vm_porch_r) && (vpos_r < vm_synch_r)) ~^ vpol_r;
      newline_r   <= hlast_s;
      newframe_r  <= frame_end_s;
      locked_r    <= (state_nx_s == LOCKED);
      underflow_r <= underflow_s;
      sync_err_r  <= sync_err_s;
      rgb_r       <= pix_nx_s;
      if (underflow_s && (uf_count_r != 16'hFFFF)) uf_count_r <= uf_count_r + 16'd1;
    end
  end

  assign o_de              = de_r;
  assign o_hsync           = hsync_r;
  assign o_vsync           = vsync_r;
  assign o_newline         = newline_r;
  assign o_newframe        = newframe_r;
  assign o_locked          = locked_r;
  assign o_underflow       = underflow_r;
  assign o_sync_err        = sync_err_r;
  assign o_underflow_count = uf_count_r;
  assign o_red             = rgb_r[3*BPC-1:2*BPC];
  assign o_grn             = rgb_r[2*BPC-1:BPC];
  assign o_blu             = rgb_r[BPC-1:0];

endmodule
